voice_mixer: RTL and testbench

Per-sample mixing stage between the wave loader's per-oscillator sample outputs and the I2S transmitter. On each audio sample tick it snapshots all oscillator samples and their on/off flags, sums the active ones serially, and divides the sum by the active count with a multi-cycle restoring divider. It presents a registered, held 8-bit mixed sample with a one-cycle valid strobe. It supersedes the combinational pre-division stream plus output divider path.

---
 rtl/voice_mixer_pkg.sv | 23 ++
 rtl/serial_divider.sv | 79 +++++++
 rtl/voice_mixer.sv | 195 +++++++++++++++++++
 tb/tb_voice_mixer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/voice_mixer_pkg.sv
// -----------------------------------------------------------------------------
// mixer_pkg
// Shared definitions for the voice mixer slice.
//   state_t          : mixer FSM states (IDLE, ACCUM, DIV, DONE)
//   SILENCE_DEFAULT  : offset-binary mid-scale, emitted when no voice is on
//   sum_width(n, w)  : width needed to sum n unsigned w-bit samples
// -----------------------------------------------------------------------------
package mixer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DIV   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [7:0] SILENCE_DEFAULT = 8'h80;

   function automatic int sum_width(input int n, input int w);
      return w + $clog2(n + 1);
   endfunction

endpackage

// File: rtl/serial_divider.sv
// -----------------------------------------------------------------------------
// serial_divider
// Restoring unsigned divider producing one quotient bit per clock.
// start loads dividend/divisor; exactly DIVIDEND_W step cycles later done
// pulses for one cycle with the full quotient valid. Remainder is discarded.
//   clk_in    : clock
//   rst_in    : asynchronous active-low reset
//   start     : one-cycle load strobe
//   dividend  : DIVIDEND_W-bit unsigned numerator
//   divisor   : DIVISOR_W-bit unsigned denominator
//   quotient  : DIVIDEND_W-bit result, stable from done until next start
//   done      : one-cycle completion strobe
// -----------------------------------------------------------------------------
module serial_divider #(
   parameter int DIVIDEND_W = 11,
   parameter int DIVISOR_W  = 3
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic                  done
);

   localparam int STEP_W = $clog2(DIVIDEND_W + 1);

   logic [DIVIDEND_W-1:0] quot_r;
   logic [DIVISOR_W-1:0]  rem_r;
   logic [DIVISOR_W-1:0]  divisor_r;
   logic [STEP_W-1:0]     steps_r;
   logic                  done_r;

   logic [DIVISOR_W:0]    trial_s;
   logic                  fits_s;

   // Trial subtraction: shift next dividend bit into the partial remainder.
   always_comb begin
      trial_s = {rem_r, quot_r[DIVIDEND_W-1]};
      fits_s  = (trial_s >= {1'b0, divisor_r});
   end

   // Load on start, then one restoring step per cycle until the step counter empties.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         quot_r    <= {DIVIDEND_W{1'b0}};
         rem_r     <= {DIVISOR_W{1'b0}};
         divisor_r <= {DIVISOR_W{1'b0}};
         steps_r   <= {STEP_W{1'b0}};
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (start) begin
            quot_r    <= dividend;
            rem_r     <= {DIVISOR_W{1'b0}};
            divisor_r <= divisor;
            steps_r   <= STEP_W'(DIVIDEND_W);
         end else if (steps_r != {STEP_W{1'b0}}) begin
            // The remainder after a successful subtract is below the divisor,
            // so dropping the top bit loses nothing.
            if (fits_s) begin
               rem_r <= DIVISOR_W'(trial_s - {1'b0, divisor_r});
            end else begin
               rem_r <= DIVISOR_W'(trial_s);
            end
            quot_r  <= {quot_r[DIVIDEND_W-2:0], fits_s};
            steps_r <= steps_r - STEP_W'(1);
            if (steps_r == STEP_W'(1)) begin
               done_r <= 1'b1;
            end
         end
      end
   end

   assign quotient = quot_r;
   assign done     = done_r;

endmodule

// File: rtl/voice_mixer.sv
// -----------------------------------------------------------------------------
// voice_mixer
// Averages the active oscillator samples once per audio tick. On tick the
// voice flags and samples are snapshotted, active voices are summed one per
// cycle, and the sum is divided by the active count in a serial divider.
// Latency from the tick edge to the valid cycle is fixed at
// NUM_OSCILLATORS + SUM_W + 2 edges regardless of how many voices are on.
//   clk_in      : 100 MHz clock
//   rst_in      : asynchronous active-low reset
//   tick_in     : one-cycle sample strobe
//   is_on_in    : per-voice active flags
//   samples_in  : packed per-voice samples, voice i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   stream_out  : mixed sample, held between updates
//   valid_out   : one-cycle pulse when stream_out updates
//   busy_out    : high while a sample is in flight (through DONE)
//   overrun_out : sticky; a tick arrived while busy
// -----------------------------------------------------------------------------
module voice_mixer
   import mixer_pkg::*;
#(
   parameter int                      NUM_OSCILLATORS = 4,
   parameter int                      SAMPLE_WIDTH    = 8,
   parameter logic [SAMPLE_WIDTH-1:0] SILENCE         = SAMPLE_WIDTH'(SILENCE_DEFAULT)
) (
   input  logic                                    clk_in,
   input  logic                                    rst_in,
   input  logic                                    tick_in,
   input  logic [NUM_OSCILLATORS-1:0]              is_on_in,
   input  logic [NUM_OSCILLATORS*SAMPLE_WIDTH-1:0] samples_in,
   output logic [SAMPLE_WIDTH-1:0]                 stream_out,
   output logic                                    valid_out,
   output logic                                    busy_out,
   output logic                                    overrun_out
);

   localparam int SUM_W = sum_width(NUM_OSCILLATORS, SAMPLE_WIDTH);
   localparam int CNT_W = $clog2(NUM_OSCILLATORS + 1);
   localparam int IDX_W = (NUM_OSCILLATORS > 1) ? $clog2(NUM_OSCILLATORS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OSCILLATORS - 1);
   localparam logic [SUM_W-1:0] Q_MAX    = SUM_W'((1 << SAMPLE_WIDTH) - 1);

   state_t                                state_r;
   state_t                                next_state_s;
   logic [NUM_OSCILLATORS-1:0]            on_snap_r;
   logic [NUM_OSCILLATORS*SAMPLE_WIDTH-1:0] samples_snap_r;
   logic [SUM_W-1:0]                      sum_r;
   logic [CNT_W-1:0]                      count_r;
   logic [IDX_W-1:0]                      idx_r;
   logic                                  div_start_r;
   logic [SAMPLE_WIDTH-1:0]               stream_r;
   logic                                  valid_r;
   logic                                  busy_r;
   logic                                  overrun_r;

   logic [SAMPLE_WIDTH-1:0]               cur_sample_s;
   logic [SUM_W-1:0]                      quotient_s;
   logic                                  div_done_s;
   logic                                  load_out_s;
   logic [SAMPLE_WIDTH-1:0]               result_s;

   serial_divider #(
      .DIVIDEND_W (SUM_W),
      .DIVISOR_W  (CNT_W)
   ) u_divider (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .start    (div_start_r),
      .dividend (sum_r),
      .divisor  (count_r),
      .quotient (quotient_s),
      .done     (div_done_s)
   );

   // Next-state decode; load_out_s marks the edge that enters DONE.
   always_comb begin
      next_state_s = state_r;
      load_out_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (tick_in) begin
               next_state_s = ACCUM;
            end else begin
               next_state_s = IDLE;
            end
         end
         ACCUM: begin
            if (idx_r == LAST_IDX) begin
               next_state_s = DIV;
            end else begin
               next_state_s = ACCUM;
            end
         end
         DIV: begin
            if (div_done_s) begin
               next_state_s = DONE;
               load_out_s   = 1'b1;
            end else begin
               next_state_s = DIV;
            end
         end
         DONE: begin
            next_state_s = IDLE;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Current voice sample and final result selection. The quotient is bounded
   // by the largest sample, so the saturation branch is purely defensive.
   always_comb begin
      cur_sample_s = samples_snap_r[int'(idx_r)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      if (count_r == {CNT_W{1'b0}}) begin
         result_s = SILENCE;
      end else if (quotient_s > Q_MAX) begin
         result_s = Q_MAX[SAMPLE_WIDTH-1:0];
      end else begin
         result_s = quotient_s[SAMPLE_WIDTH-1:0];
      end
   end

   // FSM state register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Snapshot capture and serial accumulation; div_start_r fires after the last voice.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         on_snap_r      <= {NUM_OSCILLATORS{1'b0}};
         samples_snap_r <= {(NUM_OSCILLATORS*SAMPLE_WIDTH){1'b0}};
         sum_r          <= {SUM_W{1'b0}};
         count_r        <= {CNT_W{1'b0}};
         idx_r          <= {IDX_W{1'b0}};
         div_start_r    <= 1'b0;
      end else begin
         div_start_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (tick_in) begin
                  on_snap_r      <= is_on_in;
                  samples_snap_r <= samples_in;
                  sum_r          <= {SUM_W{1'b0}};
                  count_r        <= {CNT_W{1'b0}};
                  idx_r          <= {IDX_W{1'b0}};
               end
            end
            ACCUM: begin
               if (on_snap_r[idx_r]) begin
                  sum_r   <= sum_r + SUM_W'(cur_sample_s);
                  count_r <= count_r + CNT_W'(1);
               end
               if (idx_r == LAST_IDX) begin
                  idx_r       <= {IDX_W{1'b0}};
                  div_start_r <= 1'b1;
               end else begin
                  idx_r <= idx_r + IDX_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Registered outputs: held sample, valid strobe, busy flag and sticky overrun.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         stream_r  <= SILENCE;
         valid_r   <= 1'b0;
         busy_r    <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         if (load_out_s) begin
            stream_r <= result_s;
         end
         valid_r <= load_out_s;
         busy_r  <= (next_state_s != IDLE);
         if (tick_in && (state_r != IDLE)) begin
            overrun_r <= 1'b1;
         end
      end
   end

   assign stream_out  = stream_r;
   assign valid_out   = valid_r;
   assign busy_out    = busy_r;
   assign overrun_out = overrun_r;

endmodule

// File: tb/tb_voice_mixer.sv
module tb_voice_mixer;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        tick_in;
   logic [3:0]  is_on_in;
   logic [31:0] samples_in;
   logic [7:0]  stream_out;
   logic        valid_out;
   logic        busy_out;
   logic        overrun_out;

   int checks = 0;
   int errors = 0;

   voice_mixer dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .tick_in     (tick_in),
      .is_on_in    (is_on_in),
      .samples_in  (samples_in),
      .stream_out  (stream_out),
      .valid_out   (valid_out),
      .busy_out    (busy_out),
      .overrun_out (overrun_out)
   );

   always #5 clk_in = ~clk_in;

   // Reference: mean of the active voices, truncated; silence when none active.
   function automatic logic [7:0] ref_mix(input logic [3:0] on, input logic [31:0] smp);
      int total = 0;
      int n = 0;
      for (int i = 0; i < 4; i++) begin
         if (on[i]) begin
            total += int'(smp[i*8 +: 8]);
            n++;
         end
      end
      if (n == 0) return 8'h80;
      return 8'(total / n);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Waits up to 40 edges for valid_out; lat counts edges since the caller's last edge.
   task automatic wait_valid(output int lat, output logic [7:0] val);
      lat = -1;
      val = 8'h00;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(posedge clk_in);
         #1;
         if (valid_out) begin
            lat = k;
            val = stream_out;
         end
      end
   endtask

   task automatic count_valids(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(posedge clk_in);
         #1;
         if (valid_out) cnt++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk_in);
      rst_in = 1'b0;
      tick_in = 1'b0;
      @(negedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
   endtask

   // One tick with given inputs; inputs are scrambled right after the snapshot edge.
   // Returns at the valid cycle unless tail is set.
   task automatic run_mix(input logic [3:0] on, input logic [31:0] smp,
                          input string tag, input bit tail);
      logic [7:0] exp;
      logic [7:0] prev;
      logic [7:0] val;
      int lat;
      exp  = ref_mix(on, smp);
      prev = stream_out;
      @(negedge clk_in);
      is_on_in   = on;
      samples_in = smp;
      tick_in    = 1'b1;
      @(posedge clk_in);
      #1;
      tick_in    = 1'b0;
      is_on_in   = 4'($urandom);
      samples_in = $urandom;
      chk({tag, "_busy"}, 32'(busy_out), 32'd1);
      chk({tag, "_hold"}, 32'(stream_out), 32'(prev));
      wait_valid(lat, val);
      chk({tag, "_lat"}, 32'(lat), 32'd17);
      chk({tag, "_val"}, 32'(val), 32'(exp));
      chk({tag, "_ovr"}, 32'(overrun_out), 32'd0);
      if (tail) begin
         @(posedge clk_in);
         #1;
         chk({tag, "_pulse"}, 32'(valid_out), 32'd0);
         chk({tag, "_idle"}, 32'(busy_out), 32'd0);
         chk({tag, "_kept"}, 32'(stream_out), 32'(exp));
      end
   endtask

   initial begin
      logic [7:0] val;
      logic [3:0] on;
      logic [31:0] smp;
      int lat;
      int cnt;

      rst_in     = 1'b0;
      tick_in    = 1'b0;
      is_on_in   = 4'h0;
      samples_in = 32'h0;
      repeat (3) @(negedge clk_in);
      chk("rst_stream", 32'(stream_out), 32'h80);
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_busy", 32'(busy_out), 32'd0);
      chk("rst_ovr", 32'(overrun_out), 32'd0);
      rst_in = 1'b1;

      // Directed mixes.
      run_mix(4'hF, {8'd40, 8'd30, 8'd20, 8'd10}, "avg4", 1'b1);
      chk("avg4_const", 32'(stream_out), 32'd25);
      run_mix(4'b0101, {8'd255, 8'd101, 8'd255, 8'd200}, "pair", 1'b1);
      chk("pair_const", 32'(stream_out), 32'd150);
      run_mix(4'b0000, $urandom, "none", 1'b1);
      chk("none_const", 32'(stream_out), 32'h80);
      run_mix(4'b0001, {8'd0, 8'd0, 8'd0, 8'hFF}, "one_ff", 1'b1);
      chk("one_ff_const", 32'(stream_out), 32'hFF);
      run_mix(4'b1111, 32'hFFFF_FFFF, "all_ff", 1'b1);
      chk("all_ff_const", 32'(stream_out), 32'hFF);

      // Randomised mixes against the reference.
      for (int r = 0; r < 12; r++) begin
         run_mix(4'($urandom), $urandom, "rand", 1'b1);
      end

      // Second tick five edges after the first is dropped.
      on  = 4'b1011;
      smp = {8'd7, 8'd99, 8'd60, 8'd200};
      @(negedge clk_in);
      is_on_in   = on;
      samples_in = smp;
      tick_in    = 1'b1;
      @(posedge clk_in);
      #1;
      tick_in    = 1'b0;
      samples_in = 32'h0102_0304;
      is_on_in   = 4'b1111;
      repeat (4) @(posedge clk_in);
      #1;
      tick_in = 1'b1;
      @(posedge clk_in);
      #1;
      tick_in = 1'b0;
      wait_valid(lat, val);
      chk("ovr_lat", 32'(lat), 32'd12);
      chk("ovr_val", 32'(val), 32'(ref_mix(on, smp)));
      count_valids(40, cnt);
      chk("ovr_single", 32'(cnt), 32'd0);
      chk("ovr_flag", 32'(overrun_out), 32'd1);
      do_reset();
      #1;
      chk("ovr_cleared", 32'(overrun_out), 32'd0);

      // Reset during DIV aborts the sample.
      run_mix(4'hF, {8'd40, 8'd30, 8'd20, 8'd10}, "pre_abort", 1'b1);
      @(negedge clk_in);
      is_on_in   = 4'b0110;
      samples_in = 32'h11_22_33_44;
      tick_in    = 1'b1;
      @(posedge clk_in);
      #1;
      tick_in = 1'b0;
      repeat (8) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      #1;
      chk("abort_stream", 32'(stream_out), 32'h80);
      chk("abort_busy", 32'(busy_out), 32'd0);
      chk("abort_valid", 32'(valid_out), 32'd0);
      @(negedge clk_in);
      rst_in = 1'b1;
      count_valids(30, cnt);
      chk("abort_novalid", 32'(cnt), 32'd0);
      run_mix(4'($urandom), $urandom, "post_abort", 1'b1);

      // Tick on the DONE->IDLE edge is an overrun.
      run_mix(4'b0011, {8'd0, 8'd0, 8'd9, 8'd4}, "edge_done", 1'b0);
      tick_in = 1'b1;
      @(posedge clk_in);
      #1;
      tick_in = 1'b0;
      chk("done_edge_ovr", 32'(overrun_out), 32'd1);
      count_valids(30, cnt);
      chk("done_edge_novalid", 32'(cnt), 32'd0);
      do_reset();

      // Tick on the first IDLE cycle after DONE is accepted.
      run_mix(4'b1100, {8'd50, 8'd70, 8'd0, 8'd0}, "edge_idle", 1'b0);
      @(posedge clk_in);
      #1;
      on  = 4'b0111;
      smp = {8'd255, 8'd3, 8'd128, 8'd77};
      is_on_in   = on;
      samples_in = smp;
      tick_in    = 1'b1;
      @(posedge clk_in);
      #1;
      tick_in = 1'b0;
      wait_valid(lat, val);
      chk("idle_edge_lat", 32'(lat), 32'd17);
      chk("idle_edge_val", 32'(val), 32'(ref_mix(on, smp)));
      chk("idle_edge_ovr", 32'(overrun_out), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
